// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU definitions: operand/opcode widths, opcode
//            enumeration and a legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // Opcodes 1010..1111 are unassigned and flagged as errors.
  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return (op <= 4'b1001);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler_if
// Purpose  : Request/response bundle between datapath clients and the
//            shared-ALU scheduler. master = clients/consumer side,
//            slave = scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rr_scheduler_if
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*XLEN-1:0]     req_a;
  logic [NUM_REQ*XLEN-1:0]     req_b;
  logic [NUM_REQ*ALU_OP_W-1:0] req_op;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [XLEN-1:0]             rsp_result;
  logic                        rsp_zero;
  logic                        rsp_err;
  logic [31:0]                 ops_done;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ops_done
  );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Combinational 32-bit integer ALU; unassigned opcodes give a
//            zero result with err set.
// Revision : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
(
  input  wire logic [XLEN-1:0]     a,
  input  wire logic [XLEN-1:0]     b,
  input  wire logic [ALU_OP_W-1:0] op,
  output logic      [XLEN-1:0]     result,
  output logic                     err
);

  // Opcode decode; shifts use the low five bits of b.
  always_comb begin
    result = '0;
    err    = !is_legal_op(op);
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin winner search starting at an
//            internal pointer; pointer moves past the winner on advance.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic [N-1:0]         req,
  input  wire logic                 advance,
  output logic      [N-1:0]         grant_onehot,
  output logic      [$clog2(N)-1:0] grant_idx
);
  localparam int W = $clog2(N);
  localparam logic [W:0]   c_num  = (W+1)'(N);
  localparam logic [W-1:0] c_last = W'(N-1);

  logic [W-1:0] r_ptr;
  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;
  logic         w_found;

  // Rotate requests so that bit 0 corresponds to the pointer position.
  assign w_rot = N'({req, req} >> r_ptr);

  // First set bit of the rotated vector, mapped back to an absolute index.
  always_comb begin
    w_found      = 1'b0;
    w_off        = '0;
    grant_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = W'(k);
      end
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    grant_idx = (w_sum >= c_num) ? W'(w_sum - c_num) : w_sum[W-1:0];
    if (w_found) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  // Pointer moves one past the granted index only when a grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == c_last) ? '0 : grant_idx + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Round-robin sharing of one ALU among NUM_REQ requesters with
//            a single registered, ID-tagged response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  alu_rr_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_can_issue;
  logic                w_issue;
  logic [XLEN-1:0]     w_a;
  logic [XLEN-1:0]     w_b;
  logic [ALU_OP_W-1:0] w_op;
  logic [XLEN-1:0]     w_result;
  logic                w_err;

  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [XLEN-1:0]     r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_err;
  logic [31:0]         r_ops_done;

  // A new op may enter when the response slot is empty or drains this cycle.
  assign w_can_issue   = !r_rsp_valid || bus.rsp_ready;
  assign w_issue       = w_can_issue && (|w_grant) && !rst;
  assign bus.req_ready = w_issue ? w_grant : '0;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.req_valid),
    .advance      (w_issue),
    .grant_onehot (w_grant),
    .grant_idx    (w_grant_idx)
  );

  // One-hot operand mux from the winning requester into the ALU.
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a  = bus.req_a[XLEN*i +: XLEN];
        w_b  = bus.req_b[XLEN*i +: XLEN];
        w_op = bus.req_op[ALU_OP_W*i +: ALU_OP_W];
      end
    end
  end

  alu u_alu (
    .a      (w_a),
    .b      (w_b),
    .op     (w_op),
    .result (w_result),
    .err    (w_err)
  );

  // Response register and completed-handshake counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      if (w_issue) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= w_grant_idx;
        r_rsp_result <= w_result;
        r_rsp_zero   <= (w_result == '0);
        r_rsp_err    <= w_err;
      end else if (bus.rsp_ready) begin
        r_rsp_valid  <= 1'b0;
      end
      if (r_rsp_valid && bus.rsp_ready) begin
        r_ops_done <= r_ops_done + 32'd1;
      end
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.ops_done   = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Self-checking bench for alu_rr_scheduler (NUM_REQ = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

  localparam int NREQ = 4;

  logic clk;
  logic rst;

  alu_rr_scheduler_if #(.NUM_REQ(NREQ)) bus ();

  alu_rr_scheduler #(.NUM_REQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester operand storage packed onto the bus.
  logic [31:0] a_arr  [NREQ];
  logic [31:0] b_arr  [NREQ];
  logic [3:0]  op_arr [NREQ];

  // Reference model state.
  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  bit          m_zero;
  bit          m_err;
  logic [31:0] m_ops;
  int          m_ptr;
  int          g_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = a_arr[i];
      bus.req_b[32*i +: 32] = b_arr[i];
      bus.req_op[4*i +: 4]  = op_arr[i];
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0;
    m_ops = '0; m_ptr = 0; g_last = -1;
  endtask

  // Behavioural ALU straight from the opcode table.
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output bit e);
    int sh;
    sh = int'(b % 32);
    e  = 0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = $signed(a) >>> sh;
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = '0; e = 1; end
    endcase
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input logic [3:0] v, input logic rr);
    int w;
    int idx;
    bit can;
    logic [3:0] er;
    logic [31:0] r;
    bit e;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #1;
    can = !m_valid || rr;
    w   = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && ((v >> idx) & 4'd1) != 4'd0) w = idx;
    end
    er = (can && w >= 0) ? 4'(1 << w) : 4'd0;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    @(posedge clk);
    if (m_valid && rr) m_ops = m_ops + 32'd1;
    if (can && w >= 0) begin
      alu_model(op_arr[w], a_arr[w], b_arr[w], r, e);
      m_valid = 1; m_id = w; m_res = r; m_zero = (r == 0); m_err = e;
      m_ptr = (w + 1) % NREQ;
      g_last = w;
    end else begin
      g_last = -1;
      if (rr) m_valid = 0;
    end
    #1;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("rsp_result", bus.rsp_result, m_res);
      check("rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
      check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
    check("ops_done", bus.ops_done, m_ops);
  endtask

  // Reset asserted away from the edge, released at posedge+1.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int waits;
    bit got0;
    int exp_g [5];

    vecs[0]  = '{0, 32'd5,          32'd3,          4'd0,  32'd8,          1'b0, 1'b0};
    vecs[1]  = '{1, 32'd7,          32'd7,          4'd1,  32'd0,          1'b1, 1'b0};
    vecs[2]  = '{2, 32'd11,         32'd22,         4'hF,  32'd0,          1'b1, 1'b1};
    vecs[3]  = '{3, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd2,  32'h00F0_00F0,  1'b0, 1'b0};
    vecs[4]  = '{0, 32'h0000_00F0,  32'h0000_0F00,  4'd3,  32'h0000_0FF0,  1'b0, 1'b0};
    vecs[5]  = '{1, 32'hFFFF_FFFF,  32'h1234_5678,  4'd4,  32'hEDCB_A987,  1'b0, 1'b0};
    vecs[6]  = '{2, 32'd1,          32'd31,         4'd5,  32'h8000_0000,  1'b0, 1'b0};
    vecs[7]  = '{3, 32'h8000_0000,  32'd4,          4'd6,  32'h0800_0000,  1'b0, 1'b0};
    vecs[8]  = '{0, 32'h8000_0000,  32'd4,          4'd7,  32'hF800_0000,  1'b0, 1'b0};
    vecs[9]  = '{1, 32'hFFFF_FFFF,  32'd1,          4'd8,  32'd1,          1'b0, 1'b0};
    vecs[10] = '{2, 32'hFFFF_FFFF,  32'd1,          4'd9,  32'd0,          1'b1, 1'b0};
    vecs[11] = '{3, 32'd9,          32'd9,          4'hA,  32'd0,          1'b1, 1'b1};
    vecs[12] = '{0, 32'd3,          32'd5,          4'd1,  32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[13] = '{1, 32'd1,          32'h21,         4'd5,  32'd2,          1'b0, 1'b0};

    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'd0; b_arr[i] = 32'd0; op_arr[i] = 4'd0;
    end
    pack_ops();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_ops_done", bus.ops_done, 32'd0);
    rst = 1'b0;
    bus.req_valid = 4'b0000;

    // Single-op table against hand-computed results.
    for (int i = 0; i < 14; i++) begin
      a_arr[vecs[i].r]  = vecs[i].a;
      b_arr[vecs[i].r]  = vecs[i].b;
      op_arr[vecs[i].r] = vecs[i].op;
      pack_ops();
      cycle(4'(1 << vecs[i].r), 1'b1);
      check("vec_id", 32'(bus.rsp_id), 32'(vecs[i].r));
      check("vec_result", bus.rsp_result, vecs[i].res);
      check("vec_zero", 32'(bus.rsp_zero), 32'(vecs[i].zero));
      check("vec_err", 32'(bus.rsp_err), 32'(vecs[i].err));
    end
    cycle(4'b0000, 1'b1);
    check("vec_ops_total", bus.ops_done, 32'd14);

    // Round-robin order from reset with all requesters busy.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'(i * 10); b_arr[i] = 32'(i + 1); op_arr[i] = 4'(i);
    end
    pack_ops();
    exp_g = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1);
      check("rr_grant", 32'(g_last), 32'(exp_g[i]));
      check("rr_rsp_id", 32'(bus.rsp_id), 32'(exp_g[i]));
    end

    // Backpressure: three stalled cycles, then the slot drains and refills.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0);
      check("bp_no_grant", 32'(g_last), 32'hFFFF_FFFF);
    end
    cycle(4'b1111, 1'b1);
    check("bp_resume_grant", 32'(g_last), 32'd1);

    // Reset with a held response and three pending requesters.
    cycle(4'b1110, 1'b0);
    bus.req_valid = 4'b1110;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_ops_done", bus.ops_done, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(4'b1110, 1'b1);
    check("post_rst_grant", 32'(g_last), 32'd1);

    // Fairness: requester 0 joins while 1..3 stay busy.
    cycle(4'b1110, 1'b1);
    cycle(4'b1110, 1'b1);
    waits = 0;
    got0  = 0;
    for (int i = 0; i < 8; i++) begin
      if (!got0) begin
        cycle(4'b1111, 1'b1);
        if (g_last == 0) got0 = 1;
        else waits++;
      end
    end
    check("fair_granted", 32'(got0), 32'd1);
    check("fair_wait_ok", 32'(waits <= NREQ - 1), 32'd1);

    // Counter wrap.
    cycle(4'b0000, 1'b1);
    force dut.r_ops_done = 32'hFFFF_FFFE;
    #1;
    release dut.r_ops_done;
    m_ops = 32'hFFFF_FFFE;
    cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b1);
    check("wrap_max", bus.ops_done, 32'hFFFF_FFFF);
    cycle(4'b0000, 1'b1);
    check("wrap_zero", bus.ops_done, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i]  = $urandom;
        b_arr[i]  = ($urandom_range(0, 3) == 0) ? a_arr[i] : 32'($urandom);
        op_arr[i] = 4'($urandom_range(0, 15));
      end
      pack_ops();
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
